// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, decode enums, decoded-instruction record.
package core_pkg;

  // Widest supported datapath; narrower configurations truncate on use.
  localparam int XLEN_MAX = 64;

  typedef logic [4:0] reg_index_t;

  // RV32/RV64 base opcode map, instr[6:2].
  typedef enum logic [4:0] {
    OPC_LOAD      = 5'b00000,
    OPC_MISC_MEM  = 5'b00011,
    OPC_OP_IMM    = 5'b00100,
    OPC_AUIPC     = 5'b00101,
    OPC_OP_IMM_32 = 5'b00110,
    OPC_STORE     = 5'b01000,
    OPC_OP        = 5'b01100,
    OPC_LUI       = 5'b01101,
    OPC_OP_32     = 5'b01110,
    OPC_BRANCH    = 5'b11000,
    OPC_JALR      = 5'b11001,
    OPC_JAL       = 5'b11011,
    OPC_SYSTEM    = 5'b11100
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_UIMM  = 3'd6,
    FMT_OTHER = 3'd7
  } instr_format_e;

  typedef enum logic [1:0] {
    RD_FROM_ALU_RESULT  = 2'd0,
    RD_FROM_MEM_LOAD    = 2'd1,
    RD_FROM_NEXT_SEQ_PC = 2'd2,
    RD_FROM_CSR         = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } dec_state_e;

  // One bit per opcode value: set when the base decoder knows the opcode.
  localparam logic [31:0] OPC_SUPPORTED =
      (32'd1 << OPC_LOAD)   | (32'd1 << OPC_MISC_MEM)  | (32'd1 << OPC_OP_IMM) |
      (32'd1 << OPC_AUIPC)  | (32'd1 << OPC_OP_IMM_32) | (32'd1 << OPC_STORE)  |
      (32'd1 << OPC_OP)     | (32'd1 << OPC_LUI)       | (32'd1 << OPC_OP_32)  |
      (32'd1 << OPC_BRANCH) | (32'd1 << OPC_JALR)      | (32'd1 << OPC_JAL)    |
      (32'd1 << OPC_SYSTEM);

  // Opcodes that only exist on RV64.
  localparam logic [31:0] OPC_RV64_ONLY =
      (32'd1 << OPC_OP_IMM_32) | (32'd1 << OPC_OP_32);

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Decoded fields carried through the stage; pc/imm sized for the widest XLEN.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    instr_format_e       format;
    reg_index_t          rs1_idx;
    reg_index_t          rs2_idx;
    reg_index_t          rd_idx;
    logic                rd_we;
    rd_src_e             rd_src;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } decoded_instr_t;

  function automatic logic opc_supported(input logic [4:0] opc);
    return OPC_SUPPORTED[opc];
  endfunction

  function automatic logic opc_rv64_only(input logic [4:0] opc);
    return OPC_RV64_ONLY[opc];
  endfunction

endpackage

// File: rtl/core_decode_imm.sv
// Immediate generator: raw instruction bits + format -> XLEN-wide immediate.
module core_decode_imm
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  instr_format_e   format_i,
  output logic [XLEN-1:0] imm_o
);

  // Sign-extend per format; UIMM is the zero-extended CSR immediate in rs1.
  always_comb begin
    imm_o = '0;
    case (format_i)
      FMT_I:    imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
      FMT_S:    imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:    imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:    imm_o = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
      FMT_J:    imm_o = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
      FMT_UIMM: imm_o = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      default:  imm_o = '0;
    endcase
  end

endmodule

// File: rtl/core_decode_stage.sv
// RV decode stage: combinational decode, 2-entry skid buffer, registered outputs.
module core_decode_stage
  import core_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit SUPPORT_M     = 1'b1,
  parameter bit SUPPORT_ZICSR = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output instr_format_e   o_format,
  output reg_index_t      o_rs1_idx,
  output reg_index_t      o_rs2_idx,
  output reg_index_t      o_rd_idx,
  output logic            o_rd_we,
  output rd_src_e         o_rd_src,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [4:0]     opc;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  reg_index_t     rd;
  instr_format_e  fmt;
  rd_src_e        rd_src;
  logic           is_csr, is_muldiv, illegal;
  logic [XLEN-1:0] imm;

  decoded_instr_t dec_d, out_q, skid_q;
  dec_state_e     state_q;
  logic           valid_q, ready_q;
  logic           accept, drain;

  assign opc    = i_instr[6:2];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd     = i_instr[11:7];

  // Instruction format from opcode (SYSTEM splits on funct3).
  always_comb begin
    fmt = FMT_OTHER;
    case (opc)
      OPC_OP, OPC_OP_32:                   fmt = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_MISC_MEM:              fmt = FMT_I;
      OPC_SYSTEM: begin
        if (!funct3[2])            fmt = FMT_I;
        else if (funct3 != 3'b100) fmt = FMT_UIMM;
        else                       fmt = FMT_OTHER;
      end
      OPC_STORE:                           fmt = FMT_S;
      OPC_BRANCH:                          fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                  fmt = FMT_U;
      OPC_JAL:                             fmt = FMT_J;
      default:                             fmt = FMT_OTHER;
    endcase
  end

  // Writeback source for rd.
  always_comb begin
    rd_src = RD_FROM_ALU_RESULT;
    if (opc == OPC_JAL || opc == OPC_JALR) rd_src = RD_FROM_NEXT_SEQ_PC;
    else if (opc == OPC_LOAD)              rd_src = RD_FROM_MEM_LOAD;
    else if (is_csr)                       rd_src = RD_FROM_CSR;
  end

  assign is_csr    = (opc == OPC_SYSTEM) && (funct3 != 3'b000);
  assign is_muldiv = ((opc == OPC_OP) || (opc == OPC_OP_32)) && (funct7 == FUNCT7_MULDIV);

  // Legality against this configuration's ISA subset.
  always_comb begin
    illegal = 1'b0;
    if (i_instr[1:0] != 2'b11)                   illegal = 1'b1;
    if (!opc_supported(opc))                     illegal = 1'b1;
    if (opc_rv64_only(opc) && (XLEN < 64))       illegal = 1'b1;
    if (is_muldiv && !SUPPORT_M)                 illegal = 1'b1;
    if (is_csr && !SUPPORT_ZICSR)                illegal = 1'b1;
  end

  core_decode_imm #(.XLEN(XLEN)) u_imm (
    .instr_i  (i_instr[31:7]),
    .format_i (fmt),
    .imm_o    (imm)
  );

  // Assemble the decoded record for the incoming word.
  always_comb begin
    dec_d                = '0;
    dec_d.pc[XLEN-1:0]   = i_pc;
    dec_d.opcode         = opc;
    dec_d.funct3         = funct3;
    dec_d.funct7         = funct7;
    dec_d.format         = fmt;
    dec_d.rs1_idx        = i_instr[19:15];
    dec_d.rs2_idx        = i_instr[24:20];
    dec_d.rd_idx         = rd;
    dec_d.rd_we          = !illegal && (fmt != FMT_S) && (fmt != FMT_B) && (rd != 5'd0);
    dec_d.rd_src         = rd_src;
    dec_d.imm[XLEN-1:0]  = imm;
    dec_d.illegal        = illegal;
  end

  assign accept = i_valid && ready_q;
  assign drain  = valid_q && i_ready;

  // Handshake FSM: out_q is the head, skid_q catches one extra word while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (i_flush) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= dec_d;
            valid_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && !drain) begin
            skid_q  <= dec_d;
            ready_q <= 1'b0;
            state_q <= ST_SKID;
          end else if (accept) begin
            out_q   <= dec_d;
          end else if (drain) begin
            valid_q <= 1'b0;
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_valid   = valid_q;
  assign o_ready   = ready_q;
  assign o_pc      = out_q.pc[XLEN-1:0];
  assign o_opcode  = out_q.opcode;
  assign o_funct3  = out_q.funct3;
  assign o_funct7  = out_q.funct7;
  assign o_format  = out_q.format;
  assign o_rs1_idx = out_q.rs1_idx;
  assign o_rs2_idx = out_q.rs2_idx;
  assign o_rd_idx  = out_q.rd_idx;
  assign o_rd_we   = out_q.rd_we;
  assign o_rd_src  = out_q.rd_src;
  assign o_imm     = out_q.imm[XLEN-1:0];
  assign o_illegal = out_q.illegal;

  // Upper record bits are always zero on narrow configurations.
  if (XLEN < XLEN_MAX) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^{out_q.pc[XLEN_MAX-1:XLEN], out_q.imm[XLEN_MAX-1:XLEN]};
  end

endmodule
